dmem_mmio_responder: RTL and testbench
======================================

Name: dmem_mmio_responder

Overview:
- Responder on the processor's data-memory port (address_dmem / data / wren / q_dmem).
- Decodes each access:
  - Low region: forwarded to the synchronous dmem RAM.
  - Top region: served by a small memory-mapped I/O block containing a cycle counter, a 4-entry output FIFO and a status register.
- Sits in the top-level wrapper between the processor and dmem.
- The output FIFO drains to an external consumer over a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 12, dmem word-address width.
- DATA_WIDTH, 32, data word width.
- MMIO_BASE, 12'hF00, first MMIO address; addresses >= MMIO_BASE are MMIO.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2).

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- address_dmem  in  12  word address from processor.
- data  in  32  write data from processor.
- wren  in  1  write enable from processor.
- q_dmem  out  32  read data to processor.
- ram_address  out  12  address to dmem RAM.
- ram_data  out  32  write data to dmem RAM.
- ram_wren  out  1  write enable to dmem RAM.
- ram_q  in  32  RAM read data; valid one clock after the address.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head this cycle.

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - cycle counter = 0, FIFO flushed (count 0), overflow = 0, region-select register = RAM.
  - out_valid = 0, out_data = 0, q_dmem = 0.
  - A reset mid-transfer discards all FIFO contents.
- Decode is combinational on address_dmem: mmio_sel = (address_dmem >= MMIO_BASE).
- RAM region:
  - ram_address = address_dmem, ram_data = data, ram_wren = wren & ~mmio_sel.
  - For MMIO accesses, ram_wren = 0; ram_address still follows address_dmem.
- Read latency is 1 clock for both regions:
  - mmio_sel and address are registered.
  - q_dmem = registered MMIO read value if the registered sel = 1, else ram_q.
- MMIO map (offset from MMIO_BASE):
  - 0x00 CYCLE, RW:
    - Free-running 32-bit counter, +1 every clock.
    - Wraps 0xFFFFFFFF -> 0.
    - Any write sets it to 0 on that edge; the write wins over the increment.
  - 0x01 OUT, WO:
    - A write pushes data into the FIFO.
    - If full and no pop in the same cycle, the push is dropped and overflow is set (sticky).
    - A read returns 0.
  - 0x02 STATUS, RW1:
    - Read: bit0 = empty, bit1 = full, bits[4:2] = count (0..4), bit8 = overflow, other bits 0.
    - Any write clears overflow.
  - Other offsets: reads return 0, writes ignored.
- Read values are sampled on the same edge as a concurrent state change, so they reflect pre-edge state:
  - A STATUS read in the cycle of a push shows the old count.
  - A CYCLE read returns the pre-increment value.
- FIFO:
  - Pop when out_valid & out_ready.
  - out_data is the head word and stays stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle:
    - Count unchanged.
    - Push accepted even when full; no overflow.
  - Push while empty: out_valid rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- No combinational path from out_ready to q_dmem.

Decomposition:
- Package dmem_map_pkg holds:
  - MMIO_BASE.
  - Offset constants OFF_CYCLE=0, OFF_OUT=1, OFF_STATUS=2.
  - STATUS bit positions.
- One sub-module, mmio_out_fifo:
  - Parameterised depth/width.
  - Ports: push, push_data, pop, head, count, full, empty.
  - Uses the same clock/reset convention.
- Decode, counter and read mux stay in the top module.

Test Plan:
1. Reset, then no access for 10 clocks; read 0xF00 -> q_dmem = 10 the next cycle (±1 per the documented sample point, which the bench checks exactly). Write 0xF00 then read -> 0, then 1.
2. RAM pass-through: write 0x123 = 0xDEADBEEF with wren=1 -> ram_wren=1, ram_address=0x123. Read 0x123 -> q_dmem=0xDEADBEEF one cycle later. A write to 0xF01 -> ram_wren=0.
3. FIFO ordering, out_ready=0:
   - Write 0xF01 with 0xA, 0xB -> out_valid=1, out_data=0xA, STATUS=0x008.
   - Raise out_ready for 2 cycles -> 0xA then 0xB; then out_valid=0, STATUS=0x001.
4. Overflow:
   - Push 5 words, out_ready=0 -> STATUS=0x112, fifth word lost.
   - Write 0xF02 -> STATUS=0x012.
   - Full plus a simultaneous push/pop -> count stays 4, no overflow.
5. Counter wrap: force the counter to 0xFFFFFFFE via hierarchical deposit; after 2 clocks it reads 0x00000000.
6. Reset asserted mid-drain with 3 entries -> out_valid=0 immediately (asynchronous). After release, STATUS=0x001 and CYCLE restarts from 0.

Source files
------------

// File: rtl/dmem_map_pkg.sv
// Address map and status-register layout shared by the dmem/MMIO responder.
package dmem_map_pkg;

    localparam int unsigned MAP_ADDR_W = 12;
    localparam int unsigned MAP_DATA_W = 32;

    localparam logic [MAP_ADDR_W-1:0] MMIO_BASE = 12'hF00;

    localparam logic [MAP_ADDR_W-1:0] OFF_CYCLE  = 12'h000;
    localparam logic [MAP_ADDR_W-1:0] OFF_OUT    = 12'h001;
    localparam logic [MAP_ADDR_W-1:0] OFF_STATUS = 12'h002;

    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_COUNT_LSB = 2;
    localparam int unsigned STAT_COUNT_MSB = 4;
    localparam int unsigned STAT_OVF_BIT   = 8;

    // STATUS word as seen by software; field order matches the bit positions above.
    typedef struct packed {
        logic [22:0] rsvd_hi;
        logic        overflow;
        logic [2:0]  rsvd_mid;
        logic [2:0]  count;
        logic        full;
        logic        empty;
    } status_t;

    function automatic status_t pack_status(input logic empty, input logic full,
                                            input logic [2:0] count, input logic overflow);
        status_t s;
        s          = '0;
        s.empty    = empty;
        s.full     = full;
        s.count    = count;
        s.overflow = overflow;
        return s;
    endfunction

endpackage

// File: rtl/mmio_out_fifo.sv
// Small circular output FIFO; head is zero while empty, push-on-full accepted only with a pop.
module mmio_out_fifo
    import dmem_map_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok_c;
    logic             push_ok_c;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees the head slot on the same edge, so a full FIFO can still take a push.
    assign pop_ok_c  = pop & ~empty;
    assign push_ok_c = push & (~full | pop_ok_c);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_c) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = CNT_W'(count_q + 1'b1);
            2'b01:   count_d = CNT_W'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: low addresses go to the dmem RAM, the top region to a
// cycle counter, an output FIFO and a status register, all with one-clock read latency.
module dmem_mmio_responder
    import dmem_map_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 12,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = ADDR_WIDTH'(dmem_map_pkg::MMIO_BASE),
    parameter int unsigned           FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_dmem,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q_dmem,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CYC_W = 32;

    logic                  mmio_sel_c;
    logic [ADDR_WIDTH-1:0] offset_c;
    logic                  cyc_wr_c;
    logic                  push_c;
    logic                  stat_wr_c;
    logic                  pop_c;
    status_t               status_c;

    logic [CYC_W-1:0]      cycle_q, cycle_d;
    logic                  ovf_q, ovf_d;
    logic                  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  live_q, live_d;

    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Address decode and RAM pass-through.
    assign mmio_sel_c  = (address_dmem >= MMIO_BASE);
    assign offset_c    = ADDR_WIDTH'(address_dmem - MMIO_BASE);
    assign ram_address = address_dmem;
    assign ram_data    = data;
    assign ram_wren    = wren & ~mmio_sel_c;

    assign cyc_wr_c  = wren & mmio_sel_c & (offset_c == ADDR_WIDTH'(OFF_CYCLE));
    assign push_c    = wren & mmio_sel_c & (offset_c == ADDR_WIDTH'(OFF_OUT));
    assign stat_wr_c = wren & mmio_sel_c & (offset_c == ADDR_WIDTH'(OFF_STATUS));
    assign pop_c     = out_valid & out_ready;

    mmio_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_c),
        .push_data (data),
        .pop       (pop_c),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_data  = fifo_head;
    assign out_valid = ~fifo_empty;

    assign status_c = pack_status(fifo_empty, fifo_full, 3'(fifo_count), ovf_q);

    // Counter, sticky overflow, and read capture using pre-edge state.
    always_comb begin
        cycle_d = CYC_W'(cycle_q + 1'b1);
        ovf_d   = ovf_q;
        sel_d   = mmio_sel_c;
        live_d  = 1'b1;
        rdata_d = '0;
        if (cyc_wr_c) begin
            cycle_d = '0;
        end
        if (stat_wr_c) begin
            ovf_d = 1'b0;
        end
        if (push_c && fifo_full && !pop_c) begin
            ovf_d = 1'b1;
        end
        if (mmio_sel_c) begin
            if (offset_c == ADDR_WIDTH'(OFF_CYCLE)) begin
                rdata_d = DATA_WIDTH'(cycle_q);
            end else if (offset_c == ADDR_WIDTH'(OFF_STATUS)) begin
                rdata_d = DATA_WIDTH'(status_c);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
            ovf_q   <= 1'b0;
            sel_q   <= 1'b0;
            rdata_q <= '0;
            live_q  <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            ovf_q   <= ovf_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            live_q  <= live_d;
        end
    end

    // Read data is held at zero until the first clock after reset.
    assign q_dmem = !live_q ? '0 : (sel_q ? rdata_q : ram_q);

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: scoreboarded reads plus a vector table for FIFO behaviour.
module tb_dmem_mmio_responder;

    logic        clock;
    logic        reset;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [11:0] ram_address;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic        rdy;
        logic        chk;
        logic [31:0] exp_q;
        logic        ev;
        logic [31:0] eo;
    } vec_t;
    vec_t vq[$];

    logic [31:0] ram_mem [4096];

    dmem_mmio_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM model: read-before-write, one clock of read latency.
    always @(posedge clock) begin
        if (ram_wren) ram_mem[ram_address] <= ram_data;
        ram_q <= ram_mem[ram_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic [11:0] addr, input logic [31:0] wd, input logic wr,
                         input logic rdy, input logic chk, input logic [31:0] exp, input string name);
        sb_t e;
        address_dmem = addr;
        data         = wd;
        wren         = wr;
        out_ready    = rdy;
        if (chk) begin
            e.name = name;
            e.exp  = exp;
            sb_q.push_back(e);
        end
    endtask

    task automatic step();
        sb_t e;
        @(posedge clock);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, q_dmem, e.exp);
        end
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string name);
        drive(addr, 32'h0, 1'b0, 1'b0, 1'b1, exp, name);
        step();
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] wd);
        drive(addr, wd, 1'b1, 1'b0, 1'b0, 32'h0, "");
        step();
    endtask

    task automatic idle(input logic rdy);
        drive(12'h000, 32'h0, 1'b0, rdy, 1'b0, 32'h0, "");
        step();
    endtask

    task automatic add_vec(input logic [11:0] addr, input logic [31:0] wd, input logic w,
                           input logic rdy, input logic chk, input logic [31:0] eq,
                           input logic ev, input logic [31:0] eo);
        vec_t v;
        v.addr = addr; v.wdata = wd; v.wr = w; v.rdy = rdy;
        v.chk = chk; v.exp_q = eq; v.ev = ev; v.eo = eo;
        vq.push_back(v);
    endtask

    initial begin
        // FIFO ordering, overflow, simultaneous push/pop on full, unmapped offsets.
        add_vec(12'hF01, 32'hA, 1, 0, 0, 32'h0,   1, 32'hA);
        add_vec(12'hF01, 32'hB, 1, 0, 0, 32'h0,   1, 32'hA);
        add_vec(12'hF02, 32'h0, 0, 0, 1, 32'h008, 1, 32'hA);
        add_vec(12'h000, 32'h0, 0, 1, 0, 32'h0,   1, 32'hB);
        add_vec(12'h000, 32'h0, 0, 1, 0, 32'h0,   0, 32'h0);
        add_vec(12'hF02, 32'h0, 0, 0, 1, 32'h001, 0, 32'h0);
        add_vec(12'hF01, 32'h1, 1, 0, 0, 32'h0,   1, 32'h1);
        add_vec(12'hF01, 32'h2, 1, 0, 0, 32'h0,   1, 32'h1);
        add_vec(12'hF01, 32'h3, 1, 0, 0, 32'h0,   1, 32'h1);
        add_vec(12'hF01, 32'h4, 1, 0, 0, 32'h0,   1, 32'h1);
        add_vec(12'hF01, 32'h5, 1, 0, 0, 32'h0,   1, 32'h1);
        add_vec(12'hF02, 32'h0, 0, 0, 1, 32'h112, 1, 32'h1);
        add_vec(12'hF02, 32'h9, 1, 0, 0, 32'h0,   1, 32'h1);
        add_vec(12'hF02, 32'h0, 0, 0, 1, 32'h012, 1, 32'h1);
        add_vec(12'hF01, 32'h6, 1, 1, 0, 32'h0,   1, 32'h2);
        add_vec(12'hF02, 32'h0, 0, 0, 1, 32'h012, 1, 32'h2);
        add_vec(12'hF01, 32'h0, 0, 0, 1, 32'h0,   1, 32'h2);
        add_vec(12'hF05, 32'h7, 1, 0, 0, 32'h0,   1, 32'h2);
        add_vec(12'hF05, 32'h0, 0, 0, 1, 32'h0,   1, 32'h2);
        add_vec(12'h000, 32'h0, 0, 1, 0, 32'h0,   1, 32'h3);
        add_vec(12'h000, 32'h0, 0, 1, 0, 32'h0,   1, 32'h4);
        add_vec(12'h000, 32'h0, 0, 1, 0, 32'h0,   1, 32'h6);
        add_vec(12'h000, 32'h0, 0, 1, 0, 32'h0,   0, 32'h0);
        add_vec(12'hF02, 32'h0, 0, 0, 1, 32'h001, 0, 32'h0);

        reset = 1'b0;
        address_dmem = 12'h000; data = 32'h0; wren = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_q_dmem", q_dmem, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // Cycle counter after 10 idle clocks, then write-to-zero.
        for (int i = 0; i < 10; i++) idle(1'b0);
        rd(12'hF00, 32'd10, "cycle_after_10");
        wr(12'hF00, 32'h1234);
        rd(12'hF00, 32'd0, "cycle_after_write");
        rd(12'hF00, 32'd1, "cycle_next");

        // RAM pass-through.
        drive(12'h123, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0, "");
        #1;
        check("ram_wren_low", 32'(ram_wren), 32'h1);
        check("ram_address_low", 32'(ram_address), 32'h123);
        check("ram_data_low", ram_data, 32'hDEADBEEF);
        step();
        rd(12'h123, 32'hDEADBEEF, "ram_readback");
        drive(12'hF01, 32'h77, 1'b1, 1'b0, 1'b0, 32'h0, "");
        #1;
        check("ram_wren_mmio", 32'(ram_wren), 32'h0);
        check("ram_address_mmio", 32'(ram_address), 32'hF01);
        step();
        check("push_77_valid", 32'(out_valid), 32'h1);
        check("push_77_data", out_data, 32'h77);
        idle(1'b1);
        check("drain_77_valid", 32'(out_valid), 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].addr, vq[i].wdata, vq[i].wr, vq[i].rdy, vq[i].chk, vq[i].exp_q,
                  $sformatf("vec%0d_q", i));
            step();
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vq[i].ev));
            check($sformatf("vec%0d_data", i), out_data, vq[i].eo);
        end

        // Counter wrap through a deposited value.
        drive(12'hF00, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, "wrap_fffffffe");
        force dut.cycle_q = 32'hFFFFFFFE;
        @(negedge clock);
        release dut.cycle_q;
        step();
        rd(12'hF00, 32'hFFFFFFFF, "wrap_ffffffff");
        rd(12'hF00, 32'h00000000, "wrap_zero");

        // Asynchronous reset while draining three entries.
        wr(12'hF01, 32'h31);
        wr(12'hF01, 32'h32);
        wr(12'hF01, 32'h33);
        check("pre_reset_valid", 32'(out_valid), 32'h1);
        drive(12'h000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, "");
        #2;
        reset = 1'b0;
        #1;
        check("midreset_valid", 32'(out_valid), 32'h0);
        check("midreset_data", out_data, 32'h0);
        check("midreset_q", q_dmem, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        rd(12'hF00, 32'd0, "post_reset_cycle0");
        rd(12'hF02, 32'h001, "post_reset_status");
        rd(12'hF00, 32'd2, "post_reset_cycle2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
